// File: rtl/mdu_pkg.sv
// Shared types for the HI/LO multiply/divide unit: operation codes, FSM
// states, divide latency and the sign-application helper.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE = 3'd0,
    MULT    = 3'd1,
    MULTU   = 3'd2,
    DIV     = 3'd3,
    DIVU    = 3'd4,
    MTHI    = 3'd5,
    MTLO    = 3'd6
  } md_op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MUL      = 3'd1,
    ST_DIV_PREP = 3'd2,
    ST_DIV_ITER = 3'd3,
    ST_DIV_FIX  = 3'd4
  } mdu_state_e;

  // One prep cycle, 32 restoring steps, one fix-up cycle.
  localparam int DIV_CYCLES = 34;
  localparam int DIV_STEPS  = 32;

  // Two's-complement negate when neg is set; used for operand magnitude
  // and for restoring the signs of quotient and remainder.
  function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// 32-step unsigned restoring divider core. load_i seeds the partial
// remainder and the dividend shift register; each step_i retires one
// quotient bit. Datapath only, so no reset.
module mdu_divider (
  input  logic        clk_i,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        ge;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // A zero divisor always "fits", giving an all-ones quotient and the
  // dividend as remainder.
  always_comb begin
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvsr_d  = dvsr_q;
    shifted = {rem_q, quot_q[31]};
    diff    = shifted - {1'b0, dvsr_q};
    ge      = (shifted >= {1'b0, dvsr_q});
    if (load_i) begin
      rem_d  = 32'd0;
      quot_d = dividend_i;
      dvsr_d = divisor_i;
    end else if (step_i) begin
      rem_d  = ge ? diff[31:0] : shifted[31:0];
      quot_d = {quot_q[30:0], ge};
    end
  end

  // Divider state registers.
  always_ff @(posedge clk_i) begin
    rem_q  <= rem_d;
    quot_q <= quot_d;
    dvsr_q <= dvsr_d;
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit. Holds architectural HI/LO, runs MULT/MULTU
// over MUL_CYCLES and DIV/DIVU over DIV_CYCLES, and raises busy_o as a
// stall request while an operation is in flight.
// Optional feature macro: MDU_DIV_ZERO_FAST_EN (divide by zero completes
// after a single busy cycle). MDU_PROTOCOL_ASSERT_EN adds a simulation
// check that start_i is never raised while busy.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  md_op_e      op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  mdu_state_e  state_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [5:0]  cnt_q;
  logic        neg_quot_q;
  logic        neg_rem_q;
  logic        div_zero_q;

  logic [31:0] a_q;
  logic [31:0] b_q;
  md_op_e      op_q;

  logic        accept;
  logic        mul_signed;
  logic signed [63:0] mul_a;
  logic signed [63:0] mul_b;
  logic signed [63:0] prod_p0;
  logic        div_signed;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;
  logic        div_load;
  logic        div_step;

  localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LAST = 6'(DIV_STEPS - 1);

  // A new op is taken only in IDLE (busy_o low) and never alongside a flush.
  assign accept = start_i && (state_q == ST_IDLE) && !flush_i;

  // Operand capture at the issue edge; datapath only, so no reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      a_q  <= src_a_i;
      b_q  <= src_b_i;
      op_q <= op_i;
    end
  end

  // Product, magnitudes and sign-corrected divide results from captured operands.
  always_comb begin
    mul_signed = (op_q == MULT);
    mul_a      = {{32{mul_signed & a_q[31]}}, a_q};
    mul_b      = {{32{mul_signed & b_q[31]}}, b_q};
    prod_p0    = mul_a * mul_b;
    div_signed = (op_q == DIV);
    abs_a      = apply_sign(a_q, div_signed & a_q[31]);
    abs_b      = apply_sign(b_q, div_signed & b_q[31]);
    fix_lo     = div_zero_q ? 32'hFFFF_FFFF : apply_sign(quot, neg_quot_q);
    fix_hi     = div_zero_q ? a_q : apply_sign(rem, neg_rem_q);
  end

  assign div_load = (state_q == ST_DIV_PREP);
  assign div_step = (state_q == ST_DIV_ITER);

  mdu_divider u_divider (
    .clk_i      (clk_i),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i (abs_a),
    .divisor_i  (abs_b),
    .quot_o     (quot),
    .rem_o      (rem)
  );

  // Control FSM with registered busy/done and the architectural HI/LO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      cnt_q      <= 6'd0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush_i) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              case (op_i)
                MULT, MULTU: begin
                  state_q <= ST_MUL;
                  busy_q  <= 1'b1;
                  cnt_q   <= 6'd0;
                end
                DIV, DIVU: begin
                  busy_q <= 1'b1;
`ifdef MDU_DIV_ZERO_FAST_EN
                  if (src_b_i == 32'd0) begin
                    state_q    <= ST_DIV_FIX;
                    div_zero_q <= 1'b1;
                  end else begin
                    state_q <= ST_DIV_PREP;
                  end
`else
                  state_q <= ST_DIV_PREP;
`endif
                end
                MTHI:    hi_q <= src_a_i;
                MTLO:    lo_q <= src_a_i;
                default: ;
              endcase
            end
          end
          ST_MUL: begin
            if (cnt_q == MUL_LAST) begin
              hi_q    <= prod_p0[63:32];
              lo_q    <= prod_p0[31:0];
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
          ST_DIV_PREP: begin
            neg_quot_q <= div_signed & (a_q[31] ^ b_q[31]);
            neg_rem_q  <= div_signed & a_q[31];
            div_zero_q <= (b_q == 32'd0);
            cnt_q      <= 6'd0;
            state_q    <= ST_DIV_ITER;
          end
          ST_DIV_ITER: begin
            if (cnt_q == DIV_LAST) begin
              state_q <= ST_DIV_FIX;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
          ST_DIV_FIX: begin
            hi_q    <= fix_hi;
            lo_q    <= fix_lo;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef MDU_PROTOCOL_ASSERT_EN
  // A new issue while busy means the hazard unit failed to stall D.
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(start_i && busy_q)) else $error("mult_div_unit: start_i while busy");
    end
  end
`endif

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  md_op_e      op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests;
  int fails;
  int n;
  logic seen_done;

`ifdef MDU_DIV_ZERO_FAST_EN
  localparam int DZ_CYCLES = 1;
`else
  localparam int DZ_CYCLES = 34;
`endif

  mult_div_unit #(.MUL_CYCLES(3)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .op_i    (op),
    .src_a_i (src_a),
    .src_b_i (src_b),
    .flush_i (flush),
    .busy_o  (busy),
    .done_o  (done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single sampling edge; returns in cycle 1.
  task automatic issue(input md_op_e o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    tick();
    start = 1'b0;
    op    = MD_NONE;
    src_a = 32'd0;
    src_b = 32'd0;
  endtask

  // Count busy cycles (bounded); returns in the first non-busy cycle.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      tick();
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op    = MD_NONE;
    src_a = 32'd0;
    src_b = 32'd0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    rst_n = 1'b1;
    tick();

    // MULT -2 x 3
    issue(MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    chk("mult_busy_c1", {31'd0, busy}, 32'd1);
    chk("mult_done_c1", {31'd0, done}, 32'd0);
    wait_done(n);
    chk("mult_cycles", n, 32'd3);
    chk("mult_done", {31'd0, done}, 32'd1);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    tick();
    chk("mult_done_pulse", {31'd0, done}, 32'd0);

    // MULTU max x max, then back-to-back MULT in the done cycle
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n);
    chk("multu_cycles", n, 32'd3);
    chk("multu_done", {31'd0, done}, 32'd1);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    issue(MULT, 32'd2, 32'd3);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(n);
    chk("b2b_cycles", n, 32'd3);
    chk("b2b_hi", hi, 32'd0);
    chk("b2b_lo", lo, 32'd6);

    // Signed divides
    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(n);
    chk("div_cycles", n, 32'd34);
    chk("div_done", {31'd0, done}, 32'd1);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'd0);
    issue(DIV, 32'd7, 32'hFFFF_FFFE);
    wait_done(n);
    chk("divnegb_lo", lo, 32'hFFFF_FFFD);
    chk("divnegb_hi", hi, 32'd1);
    issue(DIVU, 32'd100, 32'd7);
    wait_done(n);
    chk("divu_cycles", n, 32'd34);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    issue(DIVU, 32'hFFFF_FFFF, 32'd16);
    wait_done(n);
    chk("divu_big_lo", lo, 32'h0FFF_FFFF);
    chk("divu_big_hi", hi, 32'd15);

    // Divide by zero
    issue(DIVU, 32'd100, 32'd0);
    wait_done(n);
    chk("dz_cycles", n, DZ_CYCLES);
    chk("dz_done", {31'd0, done}, 32'd1);
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    chk("dz_hi", hi, 32'h0000_0064);
    issue(DIV, 32'hFFFF_FFFB, 32'd0);
    wait_done(n);
    chk("dzs_cycles", n, DZ_CYCLES);
    chk("dzs_lo", lo, 32'hFFFF_FFFF);
    chk("dzs_hi", hi, 32'hFFFF_FFFB);

    // MTHI/MTLO and MD_NONE
    issue(MTHI, 32'h0000_1234, 32'd0);
    chk("mthi_hi", hi, 32'h0000_1234);
    chk("mthi_lo", lo, 32'hFFFF_FFFF);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_done", {31'd0, done}, 32'd0);
    issue(MTLO, 32'h0000_5678, 32'd0);
    chk("mtlo_lo", lo, 32'h0000_5678);
    chk("mtlo_hi", hi, 32'h0000_1234);
    issue(MD_NONE, 32'hAAAA_AAAA, 32'h5555_5555);
    chk("none_busy", {31'd0, busy}, 32'd0);
    chk("none_hi", hi, 32'h0000_1234);
    chk("none_lo", lo, 32'h0000_5678);

    // start during busy is ignored
    issue(MULT, 32'd5, 32'd6);
    start = 1'b1;
    op    = MTHI;
    src_a = 32'hDEAD_BEEF;
    tick();
    start = 1'b0;
    op    = MD_NONE;
    src_a = 32'd0;
    wait_done(n);
    chk("ign_cycles", n, 32'd2);
    chk("ign_hi", hi, 32'd0);
    chk("ign_lo", lo, 32'd30);

    // Flush at busy cycle 10 of a divide
    issue(DIV, 32'd100, 32'd7);
    repeat (9) tick();
    chk("fl_busy_c10", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_busy", {31'd0, busy}, 32'd0);
    chk("fl_hi", hi, 32'd0);
    chk("fl_lo", lo, 32'd30);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen_done = 1'b1;
      tick();
    end
    chk("fl_no_done", {31'd0, seen_done}, 32'd0);
    chk("fl_lo_after", lo, 32'd30);

    // Flush with start in IDLE suppresses MTHI
    start = 1'b1;
    op    = MTHI;
    src_a = 32'h0000_ABCD;
    flush = 1'b1;
    tick();
    start = 1'b0;
    op    = MD_NONE;
    src_a = 32'd0;
    flush = 1'b0;
    chk("flst_hi", hi, 32'd0);
    chk("flst_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-divide
    issue(DIVU, 32'd100, 32'd7);
    repeat (5) tick();
    chk("ar_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_done", {31'd0, done}, 32'd0);
    chk("ar_hi", hi, 32'd0);
    chk("ar_lo", lo, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_idle", {31'd0, busy}, 32'd0);

    // Operation after reset still works
    issue(MULTU, 32'h0001_0000, 32'h0001_0000);
    wait_done(n);
    chk("post_hi", hi, 32'd1);
    chk("post_lo", lo, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
